// File: rtl/otter_mem_arbiter_pkg.sv
// Shared types and constants for the OTTER data-memory arbiter.
// Holds the FSM encoding, port indices, the latched command layout and the range check.
package otter_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam logic PORT_P0 = 1'b0;
  localparam logic PORT_P1 = 1'b1;

  typedef struct packed {
    logic        re;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] w_data;
  } mem_cmd_t;

  // The limit is one bit wider than the address so MEM_SIZE = 2**32 stays representable.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input logic [32:0] limit);
    return ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/otter_arb_starve_ctr.sv
// Saturating count of port-0 grants made while port 1 was waiting.
// force_p1_o hands the next contested arbitration to port 1.
module otter_arb_starve_ctr
  import otter_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic p0_grant_i,
  input  logic p1_grant_i,
  input  logic p1_req_i,
  output logic force_p1_o
);

  localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (p1_grant_i) begin
      cnt_d = '0;
    end else if (p0_grant_i && p1_req_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // A limit of zero never saturates away from zero, so priority stays strict.
  assign force_p1_o = (STARVE_LIMIT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/otter_mem_arbiter.sv
// Two-port arbiter in front of the unified OTTER memory's single data port.
// Port 0 has fixed priority; port 1 is protected by a starvation counter.
module otter_mem_arbiter
  import otter_mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_SIZE     = 32'h0001_0000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // Handshake: a requester raises req with stable fields and holds it until it sees
  // its ack (high for exactly one cycle); it drops req on the edge ending that cycle.
  input  logic        i_p0_req,
  input  logic        i_p0_re,
  input  logic        i_p0_we,
  input  logic [3:0]  i_p0_sel,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_w_data,
  output logic        o_p0_ack,
  output logic        o_p0_err,
  output logic [31:0] o_p0_r_data,
  input  logic        i_p1_req,
  input  logic        i_p1_re,
  input  logic        i_p1_we,
  input  logic [3:0]  i_p1_sel,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_w_data,
  output logic        o_p1_ack,
  output logic        o_p1_err,
  output logic [31:0] o_p1_r_data,
  output logic        o_dmem_re,
  output logic        o_dmem_we,
  output logic [3:0]  o_dmem_sel,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_w_data,
  input  logic [31:0] i_dmem_r_data,
  output logic        o_busy,
  output logic [1:0]  o_dbg_state
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

  arb_state_e  state_q, state_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic        winner_q, winner_d;
  logic        err_q, err_d;
  logic        dmem_re_q, dmem_re_d;
  logic        dmem_we_q, dmem_we_d;
  logic        p0_ack_q, p0_ack_d, p0_err_q, p0_err_d;
  logic        p1_ack_q, p1_ack_d, p1_err_q, p1_err_d;
  logic [31:0] p0_r_data_q, p0_r_data_d, p1_r_data_q, p1_r_data_d;
  logic [31:0] resp_data;
  logic        p0_grant, p1_grant, force_p1, pick_p1;
  mem_cmd_t    win_cmd;
  logic        win_err;

  otter_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .p0_grant_i (p0_grant),
    .p1_grant_i (p1_grant),
    .p1_req_i   (i_p1_req),
    .force_p1_o (force_p1)
  );

  assign pick_p1 = i_p1_req && (!i_p0_req || force_p1);
  assign win_cmd = pick_p1 ? '{re: i_p1_re, we: i_p1_we, sel: i_p1_sel,
                               addr: i_p1_addr, w_data: i_p1_w_data}
                           : '{re: i_p0_re, we: i_p0_we, sel: i_p0_sel,
                               addr: i_p0_addr, w_data: i_p0_w_data};
  assign win_err = addr_out_of_range(win_cmd.addr, MEM_LIMIT);
  assign resp_data = (cmd_q.re && !err_q) ? i_dmem_r_data : 32'h0;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    winner_d    = winner_q;
    err_d       = err_q;
    dmem_re_d   = 1'b0;
    dmem_we_d   = 1'b0;
    p0_ack_d    = p0_ack_q;
    p0_err_d    = p0_err_q;
    p0_r_data_d = p0_r_data_q;
    p1_ack_d    = p1_ack_q;
    p1_err_d    = p1_err_q;
    p1_r_data_d = p1_r_data_q;
    p0_grant    = 1'b0;
    p1_grant    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_p0_req || i_p1_req) begin
          p0_grant  = !pick_p1;
          p1_grant  = pick_p1;
          winner_d  = pick_p1 ? PORT_P1 : PORT_P0;
          cmd_d     = win_cmd;
          err_d     = win_err;
          // Strobes are registered here so they are visible exactly during ISSUE.
          dmem_re_d = win_cmd.re && !win_err;
          dmem_we_d = win_cmd.we && !win_err;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP: begin
        if (winner_q == PORT_P1) begin
          p1_ack_d    = 1'b1;
          p1_err_d    = err_q;
          p1_r_data_d = resp_data;
        end else begin
          p0_ack_d    = 1'b1;
          p0_err_d    = err_q;
          p0_r_data_d = resp_data;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        p0_ack_d = 1'b0;
        p0_err_d = 1'b0;
        p1_ack_d = 1'b0;
        p1_err_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      winner_q    <= PORT_P0;
      err_q       <= 1'b0;
      dmem_re_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
      p0_ack_q    <= 1'b0;
      p0_err_q    <= 1'b0;
      p0_r_data_q <= '0;
      p1_ack_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p1_r_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      winner_q    <= winner_d;
      err_q       <= err_d;
      dmem_re_q   <= dmem_re_d;
      dmem_we_q   <= dmem_we_d;
      p0_ack_q    <= p0_ack_d;
      p0_err_q    <= p0_err_d;
      p0_r_data_q <= p0_r_data_d;
      p1_ack_q    <= p1_ack_d;
      p1_err_q    <= p1_err_d;
      p1_r_data_q <= p1_r_data_d;
    end
  end

  assign o_dmem_re     = dmem_re_q;
  assign o_dmem_we     = dmem_we_q;
  assign o_dmem_sel    = cmd_q.sel;
  assign o_dmem_addr   = cmd_q.addr;
  assign o_dmem_w_data = cmd_q.w_data;
  assign o_p0_ack      = p0_ack_q;
  assign o_p0_err      = p0_err_q;
  assign o_p0_r_data   = p0_r_data_q;
  assign o_p1_ack      = p1_ack_q;
  assign o_p1_err      = p1_err_q;
  assign o_p1_r_data   = p1_r_data_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_dbg_state   = state_q;

endmodule
